// File: rtl/nibble_serial_add_ctrl.sv
// Sequences an external 4-bit combinational adder over NIBBLES nibbles to add wide operands.
// Optional macro NIBBLE_SERIAL_SUB_EN adds a 'sub' input selecting a - b instead of a + b + cin.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                 sub,
`endif
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Handshake: start is taken on a rising edge only while ready=1; done is a
  // one-cycle pulse and sum/cout stay valid until the next done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    op_a, op_b, acc, acc_nx;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            accept, last, sub_eff;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // New nibble sum enters at the top so the LSB nibble lands at bit 0 after NIBBLES shifts.
  assign acc_nx = (acc >> 4) | (W'(add_sum) << (W - 4));
  assign last   = (cnt == CW'(NIBBLES - 1));

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = start;
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = op_a[3:0];
        add_b   = op_b[3:0];
        add_cin = carry;
        if (last) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        done     = 1'b1;
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        // Subtraction is a + ~b + 1, so B is inverted once at capture.
        op_a  <= a;
        op_b  <= sub_eff ? ~b : b;
        carry <= sub_eff | cin;
        cnt   <= '0;
        acc   <= '0;
      end else if (busy) begin
        acc   <= acc_nx;
        carry <= add_cout;
        op_a  <= op_a >> 4;
        op_b  <= op_b >> 4;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= acc_nx;
          cout <= add_cout;
        end
      end
    end
  end

endmodule
